// File: rtl/purse_controller.sv
// Purse controller: accrues periodic income into a level-capped balance and
// arbitrates unit purchases and purse upgrades against it, one result per request.
`timescale 1ns/1ps
module purse_controller #(
  parameter int MONEY_W  = 15,
  parameter int TICK_DIV = 10_000_000,
  parameter int INC_BASE = 5,
  parameter int INC_STEP = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               spend_req,
  input  logic [MONEY_W-1:0] spend_amt,
  input  logic               upgrade_req,
  output logic               spend_ack,
  output logic               spend_nak,
  output logic               upgrade_ack,
  output logic               upgrade_nak,
  output logic [MONEY_W-1:0] money,
  output logic [2:0]         level,
  output logic [MONEY_W-1:0] max_money,
  output logic [MONEY_W-1:0] upgrade_cost,
  output logic               full
);

  localparam int DIV_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int SUM_W = MONEY_W + 1;

  function automatic logic [MONEY_W-1:0] cap_of(input logic [2:0] lv);
    logic [MONEY_W-1:0] c;
    c = MONEY_W'(100);
    case (lv)
      3'd0: c = MONEY_W'(100);
      3'd1: c = MONEY_W'(300);
      3'd2: c = MONEY_W'(500);
      3'd3: c = MONEY_W'(1000);
      3'd4: c = MONEY_W'(2000);
      3'd5: c = MONEY_W'(4000);
      3'd6: c = MONEY_W'(6000);
      3'd7: c = MONEY_W'(10000);
      default: c = MONEY_W'(100);
    endcase
    return c;
  endfunction

  function automatic logic [MONEY_W-1:0] cost_of(input logic [2:0] lv);
    logic [MONEY_W-1:0] c;
    c = MONEY_W'(100);
    case (lv)
      3'd0: c = MONEY_W'(100);
      3'd1: c = MONEY_W'(200);
      3'd2: c = MONEY_W'(400);
      3'd3: c = MONEY_W'(600);
      3'd4: c = MONEY_W'(1000);
      3'd5: c = MONEY_W'(2000);
      3'd6: c = MONEY_W'(4000);
      3'd7: c = MONEY_W'(8000);
      default: c = MONEY_W'(100);
    endcase
    return c;
  endfunction

  // Clamp the one-bit-wider balance to the cap of the level being entered.
  function automatic logic [MONEY_W-1:0] sat_money(input logic [SUM_W-1:0]   sum,
                                                   input logic [MONEY_W-1:0] cap);
    return (sum > {1'b0, cap}) ? cap : sum[MONEY_W-1:0];
  endfunction

  logic [DIV_W-1:0]   div_p1;
  logic [MONEY_W-1:0] money_p1;
  logic [2:0]         level_p1;
  logic               spend_ack_p1, spend_nak_p1, upgrade_ack_p1, upgrade_nak_p1;

  logic               tick;
  logic [SUM_W-1:0]   income;
  logic               spend_ok, upgrade_ok;
  logic [2:0]         level_nx;
  logic [MONEY_W-1:0] debit;
  logic [SUM_W-1:0]   sum;
  logic [MONEY_W-1:0] money_nx;

  always_comb begin
    max_money    = cap_of(level_p1);
    upgrade_cost = (level_p1 == 3'd7) ? '0 : cost_of(level_p1);
    full         = (money_p1 == max_money);

    tick   = en && (div_p1 == DIV_W'(TICK_DIV - 1));
    income = tick ? (SUM_W'(INC_BASE) + SUM_W'(level_p1) * SUM_W'(INC_STEP)) : '0;

    // Spend wins a same-cycle collision, so an upgrade needs spend_req low.
    spend_ok   = en && spend_req && (spend_amt <= money_p1);
    upgrade_ok = en && upgrade_req && !spend_req && (level_p1 != 3'd7) &&
                 (upgrade_cost <= money_p1);

    level_nx = upgrade_ok ? (level_p1 + 3'd1) : level_p1;
    debit    = spend_ok ? spend_amt : (upgrade_ok ? upgrade_cost : '0);
    sum      = {1'b0, money_p1} - {1'b0, debit} + income;
    money_nx = sat_money(sum, cap_of(level_nx));
  end

  // Stage p1: balance, level, tick divider and result pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_p1         <= '0;
      money_p1       <= '0;
      level_p1       <= '0;
      spend_ack_p1   <= 1'b0;
      spend_nak_p1   <= 1'b0;
      upgrade_ack_p1 <= 1'b0;
      upgrade_nak_p1 <= 1'b0;
    end else begin
      if (en) begin
        div_p1 <= (div_p1 == DIV_W'(TICK_DIV - 1)) ? '0 : (div_p1 + DIV_W'(1));
      end
      money_p1       <= money_nx;
      level_p1       <= level_nx;
      spend_ack_p1   <= spend_ok;
      spend_nak_p1   <= spend_req && !spend_ok;
      upgrade_ack_p1 <= upgrade_ok;
      upgrade_nak_p1 <= upgrade_req && !upgrade_ok;
    end
  end

  assign money       = money_p1;
  assign level       = level_p1;
  assign spend_ack   = spend_ack_p1;
  assign spend_nak   = spend_nak_p1;
  assign upgrade_ack = upgrade_ack_p1;
  assign upgrade_nak = upgrade_nak_p1;

endmodule

// File: tb/tb_purse_controller.sv
// Bench for purse_controller: directed vector table, level climb, async reset
// and randomized traffic, all checked against an arithmetic purse model.
`timescale 1ns/1ps
module tb_purse_controller;

  localparam int MW = 15;
  localparam int TD = 4;
  localparam int IB = 5;
  localparam int IS = 3;

  logic          clk = 1'b0;
  logic          rst, en, spend_req, upgrade_req;
  logic [MW-1:0] spend_amt;
  logic          spend_ack, spend_nak, upgrade_ack, upgrade_nak, full;
  logic [MW-1:0] money, max_money, upgrade_cost;
  logic [2:0]    level;

  purse_controller #(.MONEY_W(MW), .TICK_DIV(TD), .INC_BASE(IB), .INC_STEP(IS)) dut (
    .clk(clk), .rst(rst), .en(en), .spend_req(spend_req), .spend_amt(spend_amt),
    .upgrade_req(upgrade_req), .spend_ack(spend_ack), .spend_nak(spend_nak),
    .upgrade_ack(upgrade_ack), .upgrade_nak(upgrade_nak), .money(money),
    .level(level), .max_money(max_money), .upgrade_cost(upgrade_cost), .full(full)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int cap_t[8]  = '{100, 300, 500, 1000, 2000, 4000, 6000, 10000};
  int cost_t[8] = '{100, 200, 400, 600, 1000, 2000, 4000, 8000};

  int m_money, m_level, m_cnt;
  bit e_sack, e_snak, e_uack, e_unak;

  typedef struct {
    int idle;
    bit e, s;
    int amt;
    bit u;
    int x_money, x_level;
    bit x_sack, x_snak, x_uack, x_unak;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_money = 0; m_level = 0; m_cnt = 0;
    e_sack = 0; e_snak = 0; e_uack = 0; e_unak = 0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_money"}, money, m_money);
    chk({tag, "_level"}, level, m_level);
    chk({tag, "_max"}, max_money, cap_t[m_level]);
    chk({tag, "_cost"}, upgrade_cost, (m_level < 7) ? cost_t[m_level] : 0);
    chk({tag, "_full"}, full, (m_money == cap_t[m_level]) ? 1 : 0);
    chk({tag, "_sack"}, spend_ack, e_sack);
    chk({tag, "_snak"}, spend_nak, e_snak);
    chk({tag, "_uack"}, upgrade_ack, e_uack);
    chk({tag, "_unak"}, upgrade_nak, e_unak);
  endtask

  // Called at a falling edge: drive, advance the model one cycle, check at next falling edge.
  task automatic step(input bit e, input bit s, input int amt, input bit u);
    bit tick, sok, uok;
    int inc, nl, nm;
    en = e; spend_req = s; spend_amt = MW'(amt); upgrade_req = u;
    tick = e && ((m_cnt % TD) == TD - 1);
    inc  = tick ? (IB + IS * m_level) : 0;
    sok  = e && s && (amt <= m_money);
    uok  = e && u && !s && (m_level < 7) && (cost_t[m_level] <= m_money);
    nl   = m_level + (uok ? 1 : 0);
    nm   = m_money - (sok ? amt : 0) - (uok ? cost_t[m_level] : 0) + inc;
    if (nm > cap_t[nl]) nm = cap_t[nl];
    e_sack = sok; e_snak = s && !sok; e_uack = uok; e_unak = u && !uok;
    m_money = nm; m_level = nl;
    if (e) m_cnt++;
    @(negedge clk);
    check_outputs("step");
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_money"}, money, 0);
    chk({tag, "_level"}, level, 0);
    chk({tag, "_max"}, max_money, 100);
    chk({tag, "_cost"}, upgrade_cost, 100);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_acks"}, {spend_ack, spend_nak, upgrade_ack, upgrade_nak}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    rst = 1'b1; en = 1'b0; spend_req = 1'b0; upgrade_req = 1'b0; spend_amt = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;

    // Saturation at the level-0 cap.
    for (int k = 1; k <= 80; k++) begin
      step(1, 0, 0, 0);
      chk("sat_ramp", money, ((5 * (k / 4)) > 100) ? 100 : 5 * (k / 4));
    end
    chk("sat_full", full, 1);

    tbl[0] = '{0,   0, 1, 75,  0, 100, 0, 0, 1, 0, 0};
    tbl[1] = '{0,   1, 1, 75,  0, 25,  0, 1, 0, 0, 0};
    tbl[2] = '{0,   1, 1, 150, 0, 25,  0, 0, 1, 0, 0};
    tbl[3] = '{1,   1, 1, 25,  0, 5,   0, 1, 0, 0, 0};
    tbl[4] = '{76,  1, 0, 0,   1, 0,   1, 0, 0, 1, 0};
    tbl[5] = '{2,   1, 0, 0,   0, 8,   1, 0, 0, 0, 0};
    tbl[6] = '{148, 1, 1, 150, 1, 150, 1, 1, 0, 0, 1};
    for (int i = 0; i < 7; i++) begin
      repeat (tbl[i].idle) step(1, 0, 0, 0);
      step(tbl[i].e, tbl[i].s, tbl[i].amt, tbl[i].u);
      chk($sformatf("vec%0d_money", i), money, tbl[i].x_money);
      chk($sformatf("vec%0d_level", i), level, tbl[i].x_level);
      chk($sformatf("vec%0d_results", i), {spend_ack, spend_nak, upgrade_ack, upgrade_nak},
          {tbl[i].x_sack, tbl[i].x_snak, tbl[i].x_uack, tbl[i].x_unak});
      if (i == 4) begin
        chk("upg_max", max_money, 300);
        chk("upg_cost", upgrade_cost, 200);
      end
    end

    // Climb to level 7 and fill the purse.
    guard = 0;
    while ((m_level < 7 || m_money < 10000) && guard < 20000) begin
      if (m_level < 7 && m_money >= cost_t[m_level]) step(1, 0, 0, 1);
      else step(1, 0, 0, 0);
      guard++;
    end
    if (guard >= 20000) begin
      total++; bad++;
      $display("FAIL climb_budget got=%0d want<%0d", guard, 20000);
    end
    chk("l7_money", money, 10000);
    chk("l7_full", full, 1);
    step(1, 0, 0, 1);
    chk("l7_unak", upgrade_nak, 1);
    chk("l7_cost", upgrade_cost, 0);
    chk("l7_level", level, 7);

    // Async reset mid-cycle with a request in flight.
    repeat (2) step(1, 0, 0, 0);
    en = 1'b1; spend_req = 1'b1; spend_amt = '0; upgrade_req = 1'b1;
    #2 rst = 1'b1;
    #1 check_reset_vals("async_rst");
    @(negedge clk);
    check_reset_vals("rst_inflight");
    spend_req = 1'b0; upgrade_req = 1'b0;
    rst = 1'b0;
    model_reset();

    // Randomized traffic.
    for (int n = 0; n < 2000; n++) begin
      step($urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 120), $urandom_range(0, 3) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
